// File: rtl/priority_grant_sequencer.sv
// priority_grant_sequencer: turns an encoded winner index into a held one-hot grant,
// then a one-cycle ack, a cool-down cycle and a return to idle.
module priority_grant_sequencer #(
    parameter int CODE_W  = 3,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [CODE_W-1:0]    code,
    input  logic                 code_valid,
    input  logic                 done,
    output logic [2**CODE_W-1:0] grant,
    output logic                 grant_valid,
    output logic [2**CODE_W-1:0] ack,
    output logic                 timeout_err,
    output logic                 abort,
    output logic                 stall
);
    localparam int N = 2**CODE_W;

    typedef enum logic [1:0] {IDLE, GRANT, ACK, COOL} state_t;

    state_t            state_q;
    logic [CODE_W-1:0] idx_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [N-1:0]      grant_q, ack_q;
    logic              grant_valid_q, timeout_err_q, abort_q, stall_q;
    logic              expired;

    assign expired     = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign ack         = ack_q;
    assign timeout_err = timeout_err_q;
    assign abort       = abort_q;
    assign stall       = stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            cnt_q         <= '0;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            ack_q         <= '0;
            timeout_err_q <= 1'b0;
            abort_q       <= 1'b0;
            stall_q       <= 1'b0;
        end else begin
            ack_q         <= '0;
            timeout_err_q <= 1'b0;
            abort_q       <= 1'b0;
            case (state_q)
                IDLE: if (en && code_valid) begin
                    state_q       <= GRANT;
                    idx_q         <= code;
                    cnt_q         <= '0;
                    grant_q       <= N'(1) << code;
                    grant_valid_q <= 1'b1;
                    stall_q       <= 1'b1;
                end
                GRANT: begin
                    cnt_q <= cnt_q + 1'b1;
                    // dropping en outranks both done and the timeout
                    if (!en) begin
                        state_q       <= IDLE;
                        grant_q       <= '0;
                        grant_valid_q <= 1'b0;
                        stall_q       <= 1'b0;
                        abort_q       <= 1'b1;
                    end else if (done || expired) begin
                        state_q       <= ACK;
                        grant_q       <= '0;
                        grant_valid_q <= 1'b0;
                        ack_q         <= N'(1) << idx_q;
                        timeout_err_q <= !done;
                    end
                end
                ACK: state_q <= COOL;
                default: begin
                    state_q <= IDLE;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_priority_grant_sequencer.sv
// tb_priority_grant_sequencer: directed and random stimulus against a transaction-level model.
module tb_priority_grant_sequencer;
    localparam int TO = 16;

    logic       clk = 0, rst = 1, en = 0, code_valid = 0, done = 0;
    logic [2:0] code = '0;
    logic [7:0] grant, ack;
    logic       grant_valid, timeout_err, abort, stall;

    priority_grant_sequencer #(.CODE_W(3), .TIMEOUT(TO), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .en(en), .code(code), .code_valid(code_valid), .done(done),
        .grant(grant), .grant_valid(grant_valid), .ack(ack), .timeout_err(timeout_err),
        .abort(abort), .stall(stall)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // model: phase 0 idle, 1 granting, 2 releasing (tail counts ack + cool cycles)
    int         m_phase = 0, m_held = 0, m_tail = 0;
    logic [2:0] m_idx = '0;
    logic [7:0] e_ack = '0;
    bit         e_to = 0, e_ab = 0;

    task automatic model_reset();
        m_phase = 0; e_ack = '0; e_to = 0; e_ab = 0;
    endtask

    task automatic model_edge();
        e_ack = '0; e_to = 0; e_ab = 0;
        if (m_phase == 0) begin
            if (en && code_valid) begin m_phase = 1; m_idx = code; m_held = 0; end
        end else if (m_phase == 1) begin
            m_held++;
            if (!en) begin
                e_ab = 1; m_phase = 0;
            end else if (done || m_held == TO) begin
                e_to = !done; e_ack = 8'd1 << m_idx; m_phase = 2; m_tail = 2;
            end
        end else begin
            m_tail--;
            if (m_tail == 0) m_phase = 0;
        end
    endtask

    task automatic check_all();
        chk("grant", grant, m_phase == 1 ? 8'd1 << m_idx : 8'd0);
        chk("grant_valid", grant_valid, m_phase == 1);
        chk("ack", ack, e_ack);
        chk("timeout_err", timeout_err, e_to);
        chk("abort", abort, e_ab);
        chk("stall", stall, m_phase != 0);
        chk("onehot", $countones(grant) <= 1 && $countones(ack) <= 1, 1);
        chk("exclusive", (grant != 0) && (ack != 0), 0);
    endtask

    task automatic step(input logic e, input logic [2:0] c, input logic v, input logic d);
        en = e; code = c; code_valid = v; done = d;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic flush();
        repeat (3) step(1, 0, 0, 0);
    endtask

    initial begin
        #12;
        chk("rst_grant", grant, 0);
        chk("rst_stall", stall, 0);
        chk("rst_ack", ack, 0);
        rst = 0;
        model_reset();
        step(1, 0, 0, 0);

        // asynchronous reset in the middle of a grant
        step(1, 5, 1, 0);
        chk("g5", grant, 8'h20);
        step(1, 5, 1, 0);
        #2 rst = 1;
        #1;
        chk("arst_grant", grant, 8'h00);
        chk("arst_stall", stall, 0);
        chk("arst_ack", ack, 0);
        model_reset();
        #2 rst = 0;
        step(1, 0, 0, 0);
        check_all();

        // done after two grant cycles
        step(1, 3, 1, 0);
        chk("g3", grant, 8'h08);
        step(1, 3, 0, 0);
        chk("g3_hold", grant, 8'h08);
        step(1, 3, 0, 1);
        chk("ack3", ack, 8'h08);
        chk("ack3_to", timeout_err, 0);
        step(1, 3, 0, 0);
        chk("cool3_stall", stall, 1);
        step(1, 3, 0, 0);
        chk("idle3_stall", stall, 0);
        flush();

        // forced release after 16 grant cycles
        step(1, 6, 1, 0);
        repeat (15) begin
            step(1, 6, 0, 0);
            chk("g6_hold", grant, 8'h40);
        end
        step(1, 6, 0, 0);
        chk("ack6", ack, 8'h40);
        chk("ack6_to", timeout_err, 1);
        flush();

        // done coinciding with the timeout edge
        step(1, 6, 1, 0);
        repeat (15) step(1, 6, 0, 0);
        step(1, 6, 0, 1);
        chk("ack6d", ack, 8'h40);
        chk("ack6d_to", timeout_err, 0);
        flush();

        // code changes during a grant are ignored
        step(1, 1, 1, 0);
        repeat (2) step(1, 7, 1, 0);
        chk("g1_frozen", grant, 8'h02);
        step(1, 7, 1, 1);
        chk("ack1", ack, 8'h02);
        step(1, 7, 1, 0);
        step(1, 7, 1, 0);
        chk("cool_nocap", grant, 8'h00);
        step(1, 7, 1, 0);
        chk("g7", grant, 8'h80);
        step(1, 7, 0, 1);
        flush();

        // en dropped during a grant, then en low while idle
        step(1, 0, 1, 0);
        chk("g0", grant, 8'h01);
        step(0, 0, 1, 0);
        chk("abort0", abort, 1);
        chk("abort0_grant", grant, 8'h00);
        chk("abort0_stall", stall, 0);
        step(0, 0, 1, 0);
        chk("en0_nogrant", grant, 8'h00);
        step(0, 4, 1, 0);
        chk("abort_once", abort, 0);
        flush();

        repeat (3000)
            step($urandom_range(0, 15) != 0, 3'($urandom), 1'($urandom), $urandom_range(0, 11) == 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
